// File: rtl/alu_seq_pkg.sv
// Shared types, encodings and decode helpers for the ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB, S_OUT} state_t;

  // The only two register addresses backed by storage
  localparam logic [4:0] REG_A = 5'b00000;
  localparam logic [4:0] REG_B = 5'b00001;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  // {writes, addr}: whether the instruction writes back, and to which register
  function automatic logic [5:0] dest_of(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    logic       wr;
    logic [4:0] addr;
    op   = instr[31:26];
    fn   = instr[5:0];
    wr   = 1'b0;
    addr = instr[15:11];
    if (op == OP_RTYPE) begin
      case (fn)
        F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
        F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: wr = 1'b1;
        default: wr = 1'b0;
      endcase
    end else begin
      addr = instr[20:16];
      case (op)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LW: wr = 1'b1;
        default: wr = 1'b0;
      endcase
    end
    return {wr, addr};
  endfunction

  function automatic logic addr_ok(input logic [4:0] a);
    return (a == REG_A) || (a == REG_B);
  endfunction

  // Source operands must both name a real register before the ALU may see the word
  function automatic logic src_ok(input logic [31:0] instr);
    return addr_ok(instr[25:21]) && addr_ok(instr[20:16]);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; head is presented combinationally.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  // A push while full is allowed only when a pop frees the slot this cycle
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rd];

  // Storage needs no reset: empty/count gate every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external combinational ALU:
// IDLE -> ISSUE -> WB -> OUT, with a two-entry register file and sticky address error.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [31:0] load_data,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  input  logic        out_ready,
  output logic        err_addr,
  output logic        busy
);

  state_t      r_state;
  logic [31:0] r_instr_q;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_res_q;
  logic [2:0]  r_flags_q;
  logic [31:0] r_regA;
  logic [31:0] r_regB;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [2:0]  r_out_flags;
  logic        r_err;

  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_head_ok;
  logic [5:0]  w_dest;
  logic        w_wb_a;
  logic        w_wb_b;
  logic        w_wb_bad;
  logic [31:0] w_regA_nxt;
  logic [31:0] w_regB_nxt;

  assign w_push    = in_valid && !w_full;
  // Head leaves the FIFO from IDLE, or when OUT hands off to the next instruction
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || (r_state == S_OUT && out_ready));
  assign w_head_ok = src_ok(w_head);

  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (in_instr),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_dest   = dest_of(r_instr_q);
  assign w_wb_a   = (r_state == S_WB) && w_dest[5] && (w_dest[4:0] == REG_A);
  assign w_wb_b   = (r_state == S_WB) && w_dest[5] && (w_dest[4:0] == REG_B);
  assign w_wb_bad = (r_state == S_WB) && w_dest[5] && !addr_ok(w_dest[4:0]);

  // Write-back outranks a preload aimed at the same register
  assign w_regA_nxt = w_wb_a ? r_res_q : (load_en && !load_sel) ? load_data : r_regA;
  assign w_regB_nxt = w_wb_b ? r_res_q : (load_en &&  load_sel) ? load_data : r_regB;

  // Register file update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regA <= '0;
      r_regB <= '0;
    end else begin
      r_regA <= w_regA_nxt;
      r_regB <= w_regB_nxt;
    end
  end

  // Main sequencer; ALU operands are captured from next-state registers on ISSUE entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_instr_q    <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_res_q      <= '0;
      r_flags_q    <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head_ok) begin
              r_instr_q <= w_head;
              r_alu_a   <= w_regA_nxt;
              r_alu_b   <= w_regB_nxt;
              r_state   <= S_ISSUE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_res_q   <= alu_result;
          r_flags_q <= alu_flags;
          r_state   <= S_WB;
        end
        S_WB: begin
          if (w_wb_bad) r_err <= 1'b1;
          r_out_valid  <= 1'b1;
          r_out_result <= r_res_q;
          r_out_flags  <= r_flags_q;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (w_pop) begin
              if (w_head_ok) begin
                r_instr_q <= w_head;
                r_alu_a   <= w_regA_nxt;
                r_alu_b   <= w_regB_nxt;
                r_state   <= S_ISSUE;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready        = !w_full;
  assign alu_instruction = r_instr_q;
  assign alu_regA        = r_alu_a;
  assign alu_regB        = r_alu_b;
  assign out_valid       = r_out_valid;
  assign out_result      = r_out_result;
  assign out_flags       = r_out_flags;
  assign err_addr        = r_err;
  assign busy            = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU alongside.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        load_en;
  logic        load_sel;
  logic [31:0] load_data;
  logic [31:0] alu_instruction;
  logic [31:0] alu_regA;
  logic [31:0] alu_regB;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_ready;
  logic        err_addr;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic saw_bad = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_result(out_result), .out_flags(out_flags),
    .out_ready(out_ready), .err_addr(err_addr), .busy(busy)
  );

  // Behavioural ALU: operands selected by rs/rt; add, sub/beq, otherwise echo imm16
  logic [31:0] m_a, m_b, m_res;
  logic        m_ovf;
  always_comb begin
    m_a   = (alu_instruction[25:21] == 5'd1) ? alu_regB : alu_regA;
    m_b   = (alu_instruction[20:16] == 5'd1) ? alu_regB : alu_regA;
    m_res = {16'h0, alu_instruction[15:0]};
    m_ovf = 1'b0;
    if (alu_instruction[31:26] == 6'b000000 && alu_instruction[5:0] == 6'b100000) begin
      m_res = m_a + m_b;
      m_ovf = (m_a[31] == m_b[31]) && (m_res[31] != m_a[31]);
    end else if ((alu_instruction[31:26] == 6'b000000 && alu_instruction[5:0] == 6'b100010) ||
                 alu_instruction[31:26] == 6'b000100) begin
      m_res = m_a - m_b;
      m_ovf = (m_a[31] != m_b[31]) && (m_res[31] != m_a[31]);
    end
  end
  assign alu_result = m_res;
  assign alu_flags  = {(m_res == 32'd0), m_res[31], m_ovf};

  // Any source address beyond 00001 reaching the ALU is a violation
  always @(posedge clk)
    if (alu_instruction[25:22] != 4'd0 || alu_instruction[20:17] != 4'd0) saw_bad = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [31:0] d);
    load_en = 1'b1; load_sel = sel; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1; in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (!out_valid && c < 30) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; load_en = 1'b0;
    load_sel = 1'b0; load_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_err",       {31'd0, err_addr},  32'd0);
    chk("rst_alu_instr", alu_instruction,    32'd0);
    chk("rst_out_result", out_result,        32'd0);

    // add rs0 rt1 rd0 with exact latency: 5 + 3
    preload(1'b0, 32'd5);
    preload(1'b1, 32'd3);
    push(32'h0001_0020);                      // E0
    chk("add_busy", {31'd0, busy}, 32'd1);
    tick();                                   // E1
    chk("add_issue_instr", alu_instruction, 32'h0001_0020);
    chk("add_issue_regA", alu_regA, 32'd5);
    tick();                                   // E2
    chk("add_e2_valid", {31'd0, out_valid}, 32'd0);
    tick();                                   // E3
    chk("add_e3_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'd8);
    chk("add_flags", {29'd0, out_flags}, 32'd0);
    chk("add_regA", dut.r_regA, 32'd8);
    chk("add_regB", dut.r_regB, 32'd3);
    tick();
    chk("add_held", {31'd0, out_valid}, 32'd1);
    accept();
    chk("add_accepted", {31'd0, out_valid}, 32'd0);

    // sub rs0 rt1 rd1, then beq rs0 rt0
    preload(1'b0, 32'h7FFF_FFFF);
    preload(1'b1, 32'd1);
    push(32'h0001_0822);
    push(32'h1000_0000);
    wait_valid("sub");
    chk("sub_result", out_result, 32'h7FFF_FFFE);
    chk("sub_flags", {29'd0, out_flags}, 32'd0);
    chk("sub_regB", dut.r_regB, 32'h7FFF_FFFE);
    accept();
    wait_valid("beq");
    chk("beq_flags", {29'd0, out_flags}, 32'h4);
    chk("beq_regA", dut.r_regA, 32'h7FFF_FFFF);
    chk("beq_regB", dut.r_regB, 32'h7FFF_FFFE);
    accept();

    // Backpressure: one result parked in OUT, then five sw words
    push(32'hAC00_0000);
    wait_valid("park");
    chk("park_result", out_result, 32'd0);
    chk("park_flags", {29'd0, out_flags}, 32'h4);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_instr = 32'hAC00_0000 | k;
      chk($sformatf("fill%0d_ready", k), {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_instr = 32'hAC00_0005;
    chk("full_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_ready1", {31'd0, in_ready}, 32'd0);
    accept();
    chk("after_take_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_valid($sformatf("drain%0d", k));
      chk($sformatf("drain%0d_result", k), out_result, k);
      accept();
    end

    // Illegal rs word dropped, legal add still completes
    preload(1'b0, 32'd10);
    preload(1'b1, 32'd20);
    push(32'h0041_0020);
    push(32'h0001_0020);
    wait_valid("legal_add");
    chk("legal_add_result", out_result, 32'd30);
    chk("err_set", {31'd0, err_addr}, 32'd1);
    chk("alu_never_bad", {31'd0, saw_bad}, 32'd0);
    chk("legal_regA", dut.r_regA, 32'd30);
    accept();

    // Preload to the same register as WB: WB wins
    push(32'h0001_0020);                      // E0
    tick(); tick();                           // E1, E2 -> WB
    load_en = 1'b1; load_sel = 1'b0; load_data = 32'hDEAD_0000;
    tick();                                   // E3
    load_en = 1'b0;
    chk("coll_regA", dut.r_regA, 32'd50);
    accept();
    // Preload to the other register during WB: both land
    push(32'h0001_0020);
    tick(); tick();
    load_en = 1'b1; load_sel = 1'b1; load_data = 32'd7;
    tick();
    load_en = 1'b0;
    chk("split_regA", dut.r_regA, 32'd70);
    chk("split_regB", dut.r_regB, 32'd7);
    chk("err_sticky", {31'd0, err_addr}, 32'd1);
    accept();

    // Asynchronous reset while parked in OUT with a word queued
    push(32'hAC00_0009);
    wait_valid("pre_reset");
    push(32'hAC00_000A);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("arst_busy",      {31'd0, busy},      32'd0);
    chk("arst_err",       {31'd0, err_addr},  32'd0);
    chk("arst_regA",      dut.r_regA,         32'd0);
    chk("arst_regB",      dut.r_regB,         32'd0);
    #2 reset = 1'b0;
    tick(); tick();
    chk("post_rst_busy",  {31'd0, busy},      32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
